// File: rtl/game_flow_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : game_pkg                                                        |
// | Brief    : Shared state encodings, widths and level helper for game flow.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package game_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned SCORE_W = 32;
    localparam int unsigned LEVEL_W = 3;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Any quotient bit above the level field pushes the result to the ceiling.
    function automatic logic [LEVEL_W-1:0] sat_level(
        input logic [SCORE_W-1:0] quot,
        input logic [LEVEL_W-1:0] max_lvl
    );
        logic [LEVEL_W-1:0] lvl;
        if (quot > {{(SCORE_W-LEVEL_W){1'b0}}, max_lvl}) begin
            lvl = max_lvl;
        end else begin
            lvl = quot[LEVEL_W-1:0];
        end
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_flow_ctrl_rise_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rise_edge                                                       |
// | Brief    : Rising-edge detector; history resets high so held inputs wait.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rise_edge
    import game_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = in & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : game_flow_ctrl                                                  |
// | Brief    : Game-session FSM, score pulses, level derivation, speed tick.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_BASE  = 25_000_000,
    parameter int unsigned TICK_DEC   = 2_500_000,
    parameter int unsigned TICK_MIN   = 5_000_000,
    parameter int unsigned LEVEL_STEP = 4,
    parameter int unsigned MAX_LEVEL  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 hit,
    input  logic                 crash,
    input  logic [SCORE_W-1:0]   score,
    output logic                 score_en,
    output logic                 score_rst,
    output logic                 gameover,
    output logic [LEVEL_W-1:0]   level,
    output logic                 tick,
    output logic [STATE_W-1:0]   state
);

    localparam int unsigned        LVL_SHIFT   = $clog2(LEVEL_STEP);
    localparam logic [CNT_W-1:0]   C_TICK_BASE = TICK_BASE;
    localparam logic [CNT_W-1:0]   C_TICK_DEC  = TICK_DEC;
    localparam logic [CNT_W-1:0]   C_TICK_MIN  = TICK_MIN;
    localparam logic [CNT_W-1:0]   C_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LEVEL_W-1:0] C_MAX_LEVEL = LEVEL_W'(MAX_LEVEL);

    // ------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------
    logic w_start_rise;
    logic w_pause_rise;
    logic w_hit_rise;

    rise_edge u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (start),
        .pulse (w_start_rise)
    );

    rise_edge u_pause_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (pause),
        .pulse (w_pause_rise)
    );

    rise_edge u_hit_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (hit),
        .pulse (w_hit_rise)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic               score_en_q,  score_en_d;
    logic               score_rst_q, score_rst_d;
    logic               gameover_q,  gameover_d;
    logic [LEVEL_W-1:0] level_q,     level_d;
    logic               tick_q,      tick_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    logic               w_new_game;
    logic [SCORE_W-1:0] w_quot;
    logic [LEVEL_W-1:0] w_level_new;
    logic [CNT_W-1:0]   w_lvl_dec;
    logic [CNT_W-1:0]   w_period;
    logic               w_expire;

    // ------------------------------------------------------------------
    // Session FSM: crash outranks pause/hit while playing
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        score_en_d  = 1'b0;
        score_rst_d = 1'b0;
        w_new_game  = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (w_start_rise) begin
                    state_d     = ST_PLAY;
                    score_rst_d = 1'b1;
                    w_new_game  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (crash) begin
                    state_d = ST_OVER;
                end else begin
                    if (w_hit_rise) begin
                        score_en_d = 1'b1;
                    end
                    if (w_pause_rise) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_pause_rise) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gameover_d = (state_d == ST_OVER);
    end

    // ------------------------------------------------------------------
    // Level: held at zero while the score counter is still being cleared
    // ------------------------------------------------------------------
    assign w_quot      = score >> LVL_SHIFT;
    assign w_level_new = sat_level(w_quot, C_MAX_LEVEL);

    always_comb begin
        level_d = level_q;
        if (w_new_game || score_rst_q) begin
            level_d = '0;
        end else if (state_q == ST_PLAY) begin
            level_d = w_level_new;
        end
    end

    // ------------------------------------------------------------------
    // Speed tick divider
    // ------------------------------------------------------------------
    assign w_lvl_dec = CNT_W'(level_q) * C_TICK_DEC;
    assign w_period  = (w_lvl_dec >= (C_TICK_BASE - C_TICK_MIN)) ? C_TICK_MIN
                                                                 : (C_TICK_BASE - w_lvl_dec);
    // >= also catches a count stranded above a freshly shortened period
    assign w_expire  = (cnt_q >= (w_period - C_ONE));

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (w_new_game) begin
            cnt_d = '0;
        end else if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
            if (w_expire) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            score_en_q  <= 1'b0;
            score_rst_q <= 1'b0;
            gameover_q  <= 1'b0;
            level_q     <= '0;
            tick_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            score_en_q  <= score_en_d;
            score_rst_q <= score_rst_d;
            gameover_q  <= gameover_d;
            level_q     <= level_d;
            tick_q      <= tick_d;
            cnt_q       <= cnt_d;
        end
    end

    assign score_en  = score_en_q;
    assign score_rst = score_rst_q;
    assign gameover  = gameover_q;
    assign level     = level_q;
    assign tick      = tick_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_game_flow_ctrl                                               |
// | Brief    : Directed bench for game_flow_ctrl with a score counter model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_game_flow_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pause;
    logic        hit;
    logic        crash;
    logic [31:0] score;
    logic        score_en;
    logic        score_rst;
    logic        gameover;
    logic [2:0]  level;
    logic        tick;
    logic [1:0]  state;

    logic        load_en;
    logic [31:0] load_val;

    int n_pass;
    int n_fail;
    int n_total;
    int n_overlap;

    game_flow_ctrl #(
        .TICK_BASE  (10),
        .TICK_DEC   (2),
        .TICK_MIN   (4),
        .LEVEL_STEP (4),
        .MAX_LEVEL  (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .hit       (hit),
        .crash     (crash),
        .score     (score),
        .score_en  (score_en),
        .score_rst (score_rst),
        .gameover  (gameover),
        .level     (level),
        .tick      (tick),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Score counter in the loop; load_en lets the bench jump the score
    always @(posedge clk) begin
        if (rst) begin
            score <= '0;
        end else if (load_en) begin
            score <= load_val;
        end else if (score_rst) begin
            score <= '0;
        end else if (score_en) begin
            score <= score + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (score_en === 1'b1 && score_rst === 1'b1) begin
            n_overlap <= n_overlap + 1;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles until the next tick, bounded at 64
    task automatic wait_tick(output int n);
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (tick === 1'b1) got = 1'b1;
        end
    endtask

    // Ticks and score_en pulses seen over k cycles
    task automatic count_pulses(input int k, output int ticks, output int ens);
        ticks = 0;
        ens   = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (i == 0) hit = 1'b0;
            if (tick === 1'b1) ticks++;
            if (score_en === 1'b1) ens++;
        end
    endtask

    initial begin
        int n;
        int t_cnt;
        int e_cnt;
        n_pass    = 0;
        n_fail    = 0;
        n_total   = 0;
        n_overlap = 0;
        rst      = 1'b1;
        start    = 1'b1;
        pause    = 1'b0;
        hit      = 1'b0;
        crash    = 1'b0;
        load_en  = 1'b0;
        load_val = '0;

        // 1. reset state, start held through reset release
        cyc(3);
        chk("rst_state", state, 0);
        chk("rst_level", level, 0);
        chk("rst_tick", tick, 0);
        chk("rst_score_en", score_en, 0);
        chk("rst_score_rst", score_rst, 0);
        chk("rst_gameover", gameover, 0);
        rst = 1'b0;
        cyc(3);
        chk("held_start_state", state, 0);
        chk("held_start_score_rst", score_rst, 0);
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        chk("start_state", state, 1);
        chk("start_score_rst", score_rst, 1);
        chk("start_level", level, 0);
        start = 1'b0;
        cyc(1);
        chk("score_rst_one_cycle", score_rst, 0);
        wait_tick(n);
        chk("first_tick_delay", n, 9);
        wait_tick(n);
        chk("tick_period_l0", n, 10);

        // 3. pause at count 5, hits ignored, resume ticks 5 cycles later
        cyc(5);
        pause = 1'b1;
        cyc(1);
        chk("pause_state", state, 2);
        chk("pause_tick", tick, 0);
        pause = 1'b0;
        hit   = 1'b1;
        count_pulses(12, t_cnt, e_cnt);
        chk("pause_no_tick", t_cnt, 0);
        chk("pause_hit_ignored", e_cnt, 0);
        chk("pause_score", score, 0);
        chk("pause_still", state, 2);
        pause = 1'b1;
        cyc(1);
        chk("resume_state", state, 1);
        pause = 1'b0;
        wait_tick(n);
        chk("resume_tick_delay", n, 5);

        // 2. four hits -> level 1 / period 8; score jumps -> level 7 / period 4
        for (int k = 0; k < 4; k++) begin
            hit = 1'b1;
            cyc(1);
            chk("hit_score_en", score_en, 1);
            hit = 1'b0;
            cyc(1);
            chk("hit_score_en_low", score_en, 0);
        end
        chk("score_after_hits", score, 4);
        cyc(1);
        chk("level_1", level, 1);
        wait_tick(n);
        wait_tick(n);
        chk("tick_period_l1", n, 8);
        load_en  = 1'b1;
        load_val = 32'd28;
        cyc(1);
        load_en = 1'b0;
        cyc(1);
        chk("level_7", level, 7);
        wait_tick(n);
        wait_tick(n);
        chk("tick_period_floor", n, 4);
        load_en  = 1'b1;
        load_val = 32'd40;
        cyc(1);
        load_en = 1'b0;
        cyc(1);
        chk("level_saturated", level, 7);

        // 5. pause and hit together: hit still counts
        pause = 1'b1;
        hit   = 1'b1;
        cyc(1);
        chk("pause_hit_score_en", score_en, 1);
        chk("pause_hit_state", state, 2);
        pause = 1'b0;
        hit   = 1'b0;
        cyc(1);
        chk("pause_hit_single", score_en, 0);
        chk("pause_hit_score", score, 41);
        pause = 1'b1;
        cyc(1);
        chk("resume2_state", state, 1);
        pause = 1'b0;

        // 4. crash beats same-cycle hit; OVER ignores hit/pause; restart
        cyc(2);
        crash = 1'b1;
        hit   = 1'b1;
        cyc(1);
        chk("crash_state", state, 3);
        chk("crash_gameover", gameover, 1);
        chk("crash_hit_dropped", score_en, 0);
        crash = 1'b0;
        hit   = 1'b0;
        cyc(1);
        chk("crash_score", score, 41);
        hit = 1'b1;
        cyc(1);
        chk("over_hit_ignored", score_en, 0);
        hit   = 1'b0;
        pause = 1'b1;
        cyc(1);
        chk("over_pause_ignored", state, 3);
        pause = 1'b0;
        count_pulses(12, t_cnt, e_cnt);
        chk("over_no_tick", t_cnt, 0);
        chk("over_score_held", score, 41);
        start = 1'b1;
        cyc(1);
        chk("restart_state", state, 1);
        chk("restart_score_rst", score_rst, 1);
        chk("restart_level", level, 0);
        chk("restart_gameover", gameover, 0);
        chk("restart_no_score_en", score_en, 0);
        start = 1'b0;
        cyc(1);
        chk("restart_rst_low", score_rst, 0);
        chk("restart_no_stale_level", level, 0);
        chk("restart_score_clear", score, 0);

        // 6. reset mid-game at count 7, level 3
        cyc(4);
        load_en  = 1'b1;
        load_val = 32'd12;
        cyc(1);
        load_en = 1'b0;
        cyc(1);
        chk("pre_rst_level", level, 3);
        rst = 1'b1;
        cyc(1);
        chk("midrst_state", state, 0);
        chk("midrst_level", level, 0);
        chk("midrst_tick", tick, 0);
        chk("midrst_score_en", score_en, 0);
        chk("midrst_score_rst", score_rst, 0);
        chk("midrst_gameover", gameover, 0);
        rst = 1'b0;
        count_pulses(20, t_cnt, e_cnt);
        chk("post_rst_no_tick", t_cnt, 0);
        chk("post_rst_idle", state, 0);

        chk("no_en_rst_overlap", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
